// File: rtl/prbs49_checker_if.sv
// Stream and statistics bundle between a PRBS-49 word source and its checker.
// The master drives the sampled words; the slave reports lock and error counts.
interface prbs49_checker_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 clear;
    logic                 valid;
    logic [48:0]          data;
    logic                 locked;
    logic                 error;
    logic [CNT_WIDTH-1:0] bit_err_cnt;
    logic [CNT_WIDTH-1:0] word_err_cnt;
    logic [CNT_WIDTH-1:0] word_cnt;

    modport master (
        output clear, valid, data,
        input  locked, error, bit_err_cnt, word_err_cnt, word_cnt
    );

    modport slave (
        input  clear, valid, data,
        output locked, error, bit_err_cnt, word_err_cnt, word_cnt
    );
endinterface

// File: rtl/prbs49_checker.sv
// PRBS-49 (x^49 + x^40 + 1, XNOR) stream checker: self-synchronising lock FSM
// plus saturating bit-error, word-error and checked-word counters.
module prbs49_checker #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    prbs49_checker_if.slave  bus
);
    localparam logic [48:0] LOCKUP = '1;

    typedef enum logic {HUNT, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [48:0]          ref_q, ref_d;
    logic                 seeded_q, seeded_d;
    logic                 error_q, error_d;
    logic [7:0]           match_q, match_d;
    logic [7:0]           miss_q, miss_d;
    logic [CNT_WIDTH-1:0] bit_q, bit_d;
    logic [CNT_WIDTH-1:0] werr_q, werr_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;

    logic [48:0]          exp_w, diff_w;
    logic [5:0]           pop_w;
    logic [CNT_WIDTH:0]   pop_ext_w, bit_sum_w;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign exp_w  = {ref_q[47:0], ref_q[48] ~^ ref_q[39]};
    assign diff_w = bus.data ^ exp_w;

    always_comb begin
        pop_w = '0;
        for (int i = 0; i < 49; i++) pop_w = pop_w + 6'(diff_w[i]);
    end

    // One extra bit of headroom exposes the carry so the add clamps instead of wrapping.
    assign pop_ext_w = {{(CNT_WIDTH-5){1'b0}}, pop_w};
    assign bit_sum_w = {1'b0, bit_q} + pop_ext_w;

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        seeded_d = seeded_q;
        match_d  = match_q;
        miss_d   = miss_q;
        bit_d    = bit_q;
        werr_d   = werr_q;
        wcnt_d   = wcnt_q;
        error_d  = 1'b0;
        if (bus.valid) begin
            unique case (state_q)
                HUNT: begin
                    ref_d    = bus.data;
                    seeded_d = 1'b1;
                    if (seeded_q && bus.data == exp_w && bus.data != LOCKUP) begin
                        match_d = match_q + 8'd1;
                        if (match_q == 8'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running reference: a corrupted word never reseeds the checker.
                    ref_d  = exp_w;
                    wcnt_d = sat_inc(wcnt_q);
                    if (diff_w != '0) begin
                        bit_d   = bit_sum_w[CNT_WIDTH] ? '1 : bit_sum_w[CNT_WIDTH-1:0];
                        werr_d  = sat_inc(werr_q);
                        error_d = 1'b1;
                        miss_d  = miss_q + 8'd1;
                        if (miss_q == 8'(UNLOCK_COUNT - 1)) begin
                            state_d  = HUNT;
                            match_d  = '0;
                            ref_d    = bus.data;
                            seeded_d = 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (bus.clear) begin
            bit_d  = '0;
            werr_d = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            ref_q    <= '0;
            seeded_q <= 1'b0;
            error_q  <= 1'b0;
            match_q  <= '0;
            miss_q   <= '0;
            bit_q    <= '0;
            werr_q   <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            seeded_q <= seeded_d;
            error_q  <= error_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            bit_q    <= bit_d;
            werr_q   <= werr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign bus.locked       = (state_q == LOCKED);
    assign bus.error        = error_q;
    assign bus.bit_err_cnt  = bit_q;
    assign bus.word_err_cnt = werr_q;
    assign bus.word_cnt     = wcnt_q;
endmodule

// File: doc/prbs49_checker.md
# prbs49_checker

Downstream consumer of the 49-bit PRBS generator: samples each 49-bit word the generator emits and checks it against the PRBS-49 recurrence (x^49 + x^40 + 1, XNOR feedback). It self-synchronises to the incoming stream, holds lock while checking, and accumulates saturating bit-error, word-error and checked-word counts for link and BER measurement.

## Interface
- LOCK_COUNT, 16: consecutive matching words in HUNT required to enter LOCKED (1..255).
- UNLOCK_COUNT, 8: consecutive mismatching words in LOCKED required to return to HUNT (1..255).
- CNT_WIDTH, 32: width of each statistics counter (8..48).

- CLK  in  1  sole clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CLEAR  in  1  synchronous clear of the three counters; lock state unaffected.
- DATA_IN  in  49  received generator word.
- DATA_VALID  in  1  DATA_IN is sampled only when high; each valid word is one generator shift after the previous valid word.
- LOCKED  out  1  checker is synchronised.
- ERROR  out  1  one-cycle pulse: last checked word mismatched.
- BIT_ERR_CNT  out  CNT_WIDTH  total mismatched bits while LOCKED.
- WORD_ERR_CNT  out  CNT_WIDTH  total mismatched words while LOCKED.
- WORD_CNT  out  CNT_WIDTH  total words checked while LOCKED.

## Operation
- next(x) = {x[47:0], x[48] ~^ x[39]}. Internal 49-bit REF register; expected word EXP = next(REF).
- Reset: state HUNT, REF = 0, SEEDED = 0, match/miss counters = 0, all outputs 0.
- HUNT, on DATA_VALID:
  - REF <= DATA_IN; SEEDED <= 1.
  - Match = SEEDED && DATA_IN == EXP && DATA_IN != 49'h1_FFFF_FFFF_FFFF (the XNOR lock-up state never counts as a match).
  - Match: match_cnt++; a match that brings match_cnt to LOCK_COUNT moves the FSM to LOCKED and clears miss_cnt. No match: match_cnt <= 0.
  - Counters and ERROR are never updated in HUNT.
- LOCKED, on DATA_VALID:
  - REF <= EXP (free-running; received data does not reseed, so one corrupted word gives exactly one word error).
  - WORD_CNT++.
  - Mismatch: D = DATA_IN ^ EXP; BIT_ERR_CNT += popcount(D) (0..49); WORD_ERR_CNT++; ERROR pulses; miss_cnt++. A mismatch that brings miss_cnt to UNLOCK_COUNT moves the FSM to HUNT with match_cnt = 0, REF <= DATA_IN, SEEDED = 1.
  - Match: miss_cnt <= 0.
- DATA_VALID low: no state, REF or counter change; ERROR low.
- All counters saturate at all-ones; the addition to BIT_ERR_CNT clamps and never wraps.
- CLEAR zeroes the three counters and has priority over a same-cycle update, discarding that word's contribution. ERROR and the FSM still act on that word.
- RESET_N assertion mid-stream returns every register to its reset value immediately; relock needs 1 + LOCK_COUNT valid words.

## Timing
- All outputs registered, updated on the CLK edge that samples the valid word.
- ERROR is high for exactly the one cycle after the edge that sampled the mismatching word.
- Lock latency from a clean stream: LOCKED rises after the edge sampling valid word number LOCK_COUNT+1 (one seed word plus LOCK_COUNT matches).
- Unlock: LOCKED falls after the edge sampling the UNLOCK_COUNT-th consecutive bad word. That word is still counted.
- Throughput: one word per cycle, no backpressure. The popcount and saturating add complete in one cycle.

## Test plan
- Generator seeded 49'h1_55AA_AA55_55AA, valid every cycle (2nd word 49'h0_AB55_54AA_AB55) -> LOCKED rises after the 17th word; counters 0; ERROR never high.
- After lock, XOR bit 0 of one word -> one ERROR pulse; BIT_ERR_CNT=1, WORD_ERR_CNT=1; LOCKED stays high; following clean words give no further errors. Repeat with 3 bits flipped -> BIT_ERR_CNT=4, WORD_ERR_CNT=2.
- After lock, drive 8 consecutive all-zero words -> LOCKED falls after the 8th; WORD_ERR_CNT=8. Resume the clean stream -> relock after 16 matches.
- Constant 49'h1_FFFF_FFFF_FFFF for 100 valid cycles -> LOCKED never rises.
- Random DATA_VALID gaps (~50%) on a clean stream -> lock after 17 valid words; WORD_CNT equals the number of valid words since lock.
- Counters preloaded near saturation by forcing a CNT_WIDTH=8 build: BIT_ERR_CNT clamps at 255. Assert CLEAR together with an error word -> counters read 0 and ERROR still pulses. Pulse RESET_N low mid-lock -> all outputs 0 immediately.
